// File: rtl/algorithm_range.sv
// Arithmetic range stream source: accepts (start, step, count) and emits
// count values start + k*step on a valid/ready stream, then completes the call.
module algorithm_range #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] start,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] sOut,
  output logic             sOut_valid,
  input  logic             sOut_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_inc;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] w_cur_next;
  logic [WIDTH-1:0] w_inc_next;
  logic [WIDTH-1:0] w_remaining_next;
  logic             w_accept;
  logic             w_xfer;

  // Handshake outputs decode straight from the state register, so sOut_ready
  // never reaches sOut_valid combinationally.
  assign in_ready   = (r_state == S_IDLE) & nrst;
  assign sOut_valid = (r_state == S_EMIT);
  assign out_valid  = (r_state == S_DONE);
  assign sOut       = r_cur;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = sOut_valid & sOut_ready;

  always_comb begin
    w_state_next     = r_state;
    w_cur_next       = r_cur;
    w_inc_next       = r_inc;
    w_remaining_next = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cur_next       = start;
          w_inc_next       = step;
          w_remaining_next = count;
          w_state_next     = (count == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_xfer) begin
          w_cur_next       = r_cur + r_inc;
          w_remaining_next = r_remaining - WIDTH'(1);
          if (r_remaining == WIDTH'(1)) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_inc       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur       <= w_cur_next;
      r_inc       <= w_inc_next;
      r_remaining <= w_remaining_next;
    end
  end

endmodule
